instr_imm_packer: RTL and testbench
===================================

# instr_imm_packer

- Encodes I-type and S-type RV32 instructions from decoded fields: opcode, registers, funct3 and a 32-bit immediate.
- Packs the immediate into the instruction bit fields, which is the inverse of the immediate sign-extension path, and range-checks it first.
- Queues each encoded word in a 2-entry output buffer, tagged with a sequential instruction-memory word address.
- Sits between the program-load/test-stimulus source and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 8, width of the output word-address counter
- BASE_ADDR, 0, address assigned to the first accepted instruction after reset

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input fields valid
- in_ready  output  1  block can accept input this cycle
- in_fmt  input  1  0 = I-type, 1 = S-type
- in_opcode  input  7  opcode
- in_funct3  input  3  funct3
- in_rd  input  5  destination register (I-type only)
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2 (S-type only)
- in_imm  input  32  signed immediate
- out_valid  output  1  buffered instruction available
- out_ready  input  1  consumer takes the head entry
- out_instr  output  32  encoded instruction at head
- out_addr  output  ADDR_W  word address at head
- err_ovf  output  1  sticky: an out-of-range immediate was seen
- err_clr  input  1  clears err_ovf

## Operation
- **Accept:** an input is accepted when in_valid && in_ready. in_ready = (count < 2).
- **Range check:** the immediate is in range iff in_imm[31:11] is all zeros or all ones, i.e. −2048..2047.
- **Packing:**
  - I-type: {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode}.
  - S-type: {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode}.
  - Unused register fields are ignored.
- **In-range accept:**
  - Push {instr, addr_cnt} into the buffer.
  - addr_cnt increments by 1 and wraps from 2^ADDR_W−1 to 0.
- **Out-of-range accept (macro off):**
  - The input is consumed and dropped.
  - Nothing is pushed and addr_cnt is unchanged.
  - err_ovf sets.
- **Buffer:**
  - 2-entry FIFO with a 1-bit read pointer, 1-bit write pointer and a 2-bit count.
  - out_valid = (count != 0). The head entry drives out_instr and out_addr.
  - A pop occurs on out_valid && out_ready.
- **Push and pop in the same cycle:**
  - With count = 1: count stays 1 and the new entry becomes the head on the next cycle.
  - With count = 2: no push is possible (in_ready = 0), so only the pop happens.
  - With count = 0: there is no pop.
- **err_ovf:**
  - Set and clear in the same cycle: set wins.
  - err_clr alone clears it on the next edge.
- **Reset values:**
  - count = 0, out_valid = 0, out_instr = 0, out_addr = 0.
  - addr_cnt = BASE_ADDR, err_ovf = 0, in_ready = 1.
  - Buffer contents are discarded.
- **Reset mid-operation:** the reset values above apply. Any pending entries are lost, and an accept in the reset cycle is ignored.

## Timing
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N, provided the buffer was empty.
- in_ready and out_valid are functions of registered count only; there is no combinational path from in_valid or out_ready.
- Throughput: 1 instruction/cycle when out_ready is held high.
- With out_ready low, 2 accepts fill the buffer, then in_ready drops.
- out_instr and out_addr are stable while out_valid && !out_ready.

## Configuration
- IMM_SAT_EN defined:
  - Out-of-range immediates are saturated to 2047 (positive) or −2048 (negative, sign = in_imm[31]).
  - The saturated instruction is pushed and consumes an address; err_ovf still sets.
- IMM_SAT_EN undefined: out-of-range inputs are dropped as described in Operation.

## Test plan
- **Reset:** assert rst for 2 cycles → out_valid = 0, in_ready = 1, err_ovf = 0. The first accepted in-range input gets out_addr = BASE_ADDR.
- **I-type:** in_fmt=0, opcode=0x13, funct3=0, rd=5, rs1=6, imm=−1 → out_instr = 0xFFF30293, out_addr = BASE_ADDR, out_valid the cycle after the accept.
- **S-type:** in_fmt=1, opcode=0x23, funct3=2, rs1=8, rs2=9, imm=0x7E4 → out_instr = 0x7E942223. Sign-extending it with the S-format decoder returns 0x000007E4.
- **Backpressure:** out_ready=0 with 3 back-to-back valid inputs → only 2 are accepted and in_ready=0 on the third cycle. Raising out_ready drains the 2 entries with consecutive addresses in order.
- **Overflow:** imm=0x00000800.
  - Macro off: no output, address not consumed, err_ovf=1. Asserting err_clr with no concurrent error clears it.
  - With IMM_SAT_EN: imm[11:0]=0x7FF is emitted.
- **Wrap:** ADDR_W=2, 5 accepts → addresses 0,1,2,3,0. Concurrent push and pop at count = 1 for 10 cycles → count stays 1 and no entry is lost.

Source files
------------

// File: rtl/instr_imm_packer.sv
// RV32 I/S-type instruction encoder with immediate range check and a 2-entry
// address-tagged output buffer. Define IMM_SAT_EN to saturate out-of-range immediates.
module instr_imm_packer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_ovf,
    input  logic              err_clr
);

    logic [1:0]        count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       buf_instr [2];
    logic [ADDR_W-1:0] buf_addr  [2];

    logic              accept;
    logic              in_range;
    logic [11:0]       imm12;
    logic [31:0]       instr;
    logic              push;
    logic              pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Bits 31:11 must all equal the sign bit for the value to fit in 12 bits.
    assign in_range  = (&in_imm[31:11]) || (~|in_imm[31:11]);

    always_comb begin
        imm12 = in_imm[11:0];
        push  = accept && in_range;
`ifdef IMM_SAT_EN
        if (!in_range) begin
            imm12 = in_imm[31] ? 12'h800 : 12'h7FF;
        end
        push = accept;
`endif
        if (in_fmt) begin
            instr = {imm12[11:5], in_rs2, in_rs1, in_funct3, imm12[4:0], in_opcode};
        end else begin
            instr = {imm12, in_rs1, in_funct3, in_rd, in_opcode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            addr_cnt <= ADDR_W'(BASE_ADDR);
            err_ovf  <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr   <= ~wr_ptr;
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !in_range) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; pointers and count gate what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_instr[wr_ptr] <= instr;
            buf_addr[wr_ptr]  <= addr_cnt;
        end
    end

    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? buf_addr[rd_ptr]  : '0;

endmodule

// File: tb/tb_instr_imm_packer.sv
// Scoreboard bench for instr_imm_packer: stimulus pushes expected words,
// a negedge monitor pops and compares on every DUT handshake.
module tb_instr_imm_packer;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned BASE_ADDR = 5;
`ifdef IMM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_ovf;
    logic              err_clr;

    instr_imm_packer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_ovf(err_ovf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] exp_addr;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", out_instr, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_addr", 32'(out_addr), 32'(e.addr));
            end
        end
    end

    // Holds one vector valid for one cycle; ovf marks an out-of-range immediate.
    task automatic issue(input logic fmt, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic [31:0] exp_instr,
                         input bit ovf, output logic acc);
        in_fmt = fmt; in_opcode = opc; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc && (!ovf || SAT)) begin
            sb.push_back('{instr: exp_instr, addr: exp_addr});
            exp_addr = exp_addr + 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_addr = ADDR_W'(BASE_ADDR);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_fmt = 1'b0; in_opcode = '0; in_funct3 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_addr = ADDR_W'(BASE_ADDR);
        @(posedge clk); #1;
        do_reset();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);

        // Basic encodings; address 5,6,7 then wrap to 0,1.
        out_ready = 1'b1;
        issue(1'b0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 0, acc);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        issue(1'b1, 7'h23, 3'd2, 5'd0, 5'd8, 5'd9, 32'h0000_07E4, 32'h7E94_2223, 0, acc);
        issue(1'b0, 7'h03, 3'd2, 5'd1, 5'd2, 5'd0, 32'h0000_07FF, 32'h7FF1_2083, 0, acc);
        issue(1'b0, 7'h13, 3'd7, 5'd31, 5'd31, 5'd5, 32'hFFFF_F800, 32'h800F_FF93, 0, acc);
        issue(1'b1, 7'h23, 3'd0, 5'd17, 5'd2, 5'd1, 32'hFFFF_FFFC, 32'hFE11_0E23, 0, acc);
        drain();

        // Positive overflow: dropped (or saturated to 2047), sticky error.
        issue(1'b0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h7FF0_0093, 1, acc);
        check("ovf_err_set", 32'(err_ovf), 32'd1);
        drain();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("ovf_err_clr", 32'(err_ovf), 32'd0);

        // Negative overflow with concurrent clear: set wins.
        err_clr = 1'b1;
        issue(1'b1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd4, 32'hFFFF_F7FF, 32'h8041_A023, 1, acc);
        err_clr = 1'b0;
        check("ovf_set_wins", 32'(err_ovf), 32'd1);
        drain();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("ovf_err_clr2", 32'(err_ovf), 32'd0);

        // Backpressure: only two accepted, third sees in_ready low.
        out_ready = 1'b0;
        issue(1'b0, 7'h13, 3'd1, 5'd10, 5'd11, 5'd0, 32'h0000_0001, 32'h0015_9513, 0, acc);
        check("bp_acc1", 32'(acc), 32'd1);
        issue(1'b0, 7'h13, 3'd1, 5'd12, 5'd13, 5'd0, 32'h0000_0002, 32'h0026_9613, 0, acc);
        check("bp_acc2", 32'(acc), 32'd1);
        issue(1'b0, 7'h13, 3'd1, 5'd14, 5'd15, 5'd0, 32'h0000_0003, 32'h0037_9713, 0, acc);
        check("bp_in_ready_low", 32'(acc), 32'd0);
        drain();

        // Push and pop together at count 1 for 10 cycles.
        out_ready = 1'b0;
        issue(1'b0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0093, 0, acc);
        out_ready = 1'b1;
        for (int unsigned i = 2; i < 12; i++) begin
            issue(1'b0, 7'h13, 3'd0, 5'(i), 5'd0, 5'd0, 32'd0, 32'h0000_0013 | (i << 7), 0, acc);
            check("pp_in_ready", 32'(acc), 32'd1);
            check("pp_out_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Reset mid-operation discards entries, error flag and address.
        out_ready = 1'b0;
        issue(1'b0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0001_0000, 32'h7FF0_0093, 1, acc);
        issue(1'b0, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd0, 32'h0000_0113, 0, acc);
        in_valid = 1'b1;
        do_reset();
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_err_ovf", 32'(err_ovf), 32'd0);
        out_ready = 1'b1;
        issue(1'b0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 0, acc);
        drain();

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
